// File: rtl/tape_pin_bridge.sv
// Bridges utm_core's symbol/decision exchange onto an off-chip tape host
// over a four-phase req/ack pin interface (read, then write+move, per step).
module tape_pin_bridge #(
    parameter logic [2:0] HALT_SYM    = 3'b111,
    parameter int         RESP_DELAY  = 2,
    parameter int         SYNC_STAGES = 2,
    parameter int         COUNT_W     = 24
) (
    input  logic               clock,
    input  logic               reset,
    output logic [2:0]         sym,
    output logic               sym_valid,
    input  logic [2:0]         new_sym,
    input  logic               direction,
    output logic               io_req,
    output logic               io_we,
    output logic [2:0]         io_wdata,
    output logic               io_dir,
    input  logic               io_ack,
    input  logic [2:0]         io_rdata,
    output logic               halted,
    output logic [COUNT_W-1:0] step_count,
    output logic [2:0]         state_dbg
);

    // Handshake: io_req rises only while synchronized ack is low, stays high
    // until synchronized ack is seen high, then drops; the next request waits
    // for synchronized ack low again. io_we/io_wdata/io_dir only change while
    // io_req and io_ack are both low.

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_REL, S_PRESENT,
        S_WAIT, S_WR_REQ, S_WR_REL, S_HALTED
    } state_t;

    localparam int WCW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [WCW-1:0]         wait_cnt;
    logic                   wait_last;
    logic                   req_nx;
    logic                   rd_capture;
    logic                   sample;
    logic                   wr_done;

    // Left out of reset so a host still holding ack is visible right after release.
    always_ff @(posedge clock) begin
        ack_sync <= {ack_sync[SYNC_STAGES-2:0], io_ack};
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign wait_last = (wait_cnt == WCW'(RESP_DELAY - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            io_req <= 1'b0;
        end else begin
            state  <= state_nx;
            io_req <= req_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_nx     = 1'b0;
        rd_capture = 1'b0;
        sample     = 1'b0;
        wr_done    = 1'b0;
        case (state)
            S_IDLE: state_nx = S_RD_REQ;
            S_RD_REQ: begin
                if (io_req && ack_s) begin
                    state_nx   = S_RD_REL;
                    rd_capture = 1'b1;
                end else begin
                    req_nx = io_req | ~ack_s;
                end
            end
            S_RD_REL: if (!ack_s) state_nx = S_PRESENT;
            S_PRESENT: state_nx = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
                    sample   = 1'b1;
                    state_nx = (new_sym == HALT_SYM) ? S_HALTED : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (io_req && ack_s) begin
                    state_nx = S_WR_REL;
                end else begin
                    req_nx = io_req | ~ack_s;
                end
            end
            S_WR_REL: begin
                if (!ack_s) begin
                    state_nx = S_RD_REQ;
                    wr_done  = 1'b1;
                end
            end
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym        <= 3'b000;
            io_we      <= 1'b0;
            io_wdata   <= 3'b000;
            io_dir     <= 1'b0;
            step_count <= '0;
            wait_cnt   <= '0;
        end else begin
            if (rd_capture) sym <= io_rdata;
            if (state == S_PRESENT) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !wait_last) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (sample && new_sym != HALT_SYM) begin
                io_wdata <= new_sym;
                io_dir   <= direction;
                io_we    <= 1'b1;
            end
            if (wr_done) begin
                io_we <= 1'b0;
                if (step_count != '1) step_count <= step_count + 1'b1;
            end
        end
    end

    assign sym_valid = (state == S_PRESENT);
    assign halted    = (state == S_HALTED);
    assign state_dbg = state;

endmodule
